// File: rtl/sample_pkg.sv
// Shared types and helpers for the registered adder.
// Holds the default width, data/flag types and the signed-overflow rule.
package sample_pkg;

   localparam int SAMPLE_WIDTH_DEF = 4;

   typedef logic [SAMPLE_WIDTH_DEF-1:0] sample_data_t;

   typedef struct packed {
      logic carry;
      logic ovf;
   } sample_flags_t;

   // Operands share a sign and the result sign differs: two's-complement overflow.
   function automatic logic sample_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/sample_add.sv
// Combinational adder core: sum, carry and signed overflow. Zero latency, no backpressure.
// With SAMPLE_SAT_EN defined, sum clamps to all ones on unsigned carry; the flags are unchanged.
module sample_add
   import sample_pkg::*;
#(
   parameter int WIDTH = SAMPLE_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0] s;

   always_comb begin
      s     = {1'b0, a} + {1'b0, b};
      carry = s[WIDTH];
      // Overflow is judged on the raw sum, never on the saturated value.
      ovf   = sample_ovf(a[WIDTH-1], b[WIDTH-1], s[WIDTH-1]);
`ifdef SAMPLE_SAT_EN
      sum   = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
      sum   = s[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/sample.sv
// Registered adder with carry, overflow and sticky overflow; one-cycle latency, no backpressure.
// Optional unsigned saturation of out when SAMPLE_SAT_EN is defined.
module sample
   import sample_pkg::*;
#(
   parameter int WIDTH = SAMPLE_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             ovf,
   output logic             ovf_sticky
);

   logic [WIDTH-1:0] sum_nxt;
   logic             carry_nxt;
   logic             ovf_nxt;
   sample_flags_t    flags_q;

   sample_add #(.WIDTH(WIDTH)) u_add (
      .a     (a),
      .b     (b),
      .sum   (sum_nxt),
      .carry (carry_nxt),
      .ovf   (ovf_nxt)
   );

   // Reset wins over the update, so the reset cycle's operands are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out        <= '0;
         flags_q    <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         out           <= sum_nxt;
         flags_q.carry <= carry_nxt;
         flags_q.ovf   <= ovf_nxt;
         ovf_sticky    <= ovf_sticky | ovf_nxt;
      end
   end

   assign carry = flags_q.carry;
   assign ovf   = flags_q.ovf;

endmodule

// File: tb/tb_sample.sv
// Scoreboard bench for sample: driver queues expected results, monitor checks one edge later.
module tb_sample;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] out;
   logic       carry;
   logic       ovf;
   logic       ovf_sticky;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef SAMPLE_SAT_EN
   localparam logic [3:0] WRAP_OUT = 4'd15;
`else
   localparam logic [3:0] WRAP_OUT = 4'd0;
`endif

   typedef struct {
      string      tag;
      logic [3:0] ia;
      logic [3:0] ib;
      logic [3:0] eo;
      logic       ec;
      logic       ev;
      logic       es;
   } exp_t;

   exp_t q[$];

   sample dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .out        (out),
      .carry      (carry),
      .ovf        (ovf),
      .ovf_sticky (ovf_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic r, input logic [3:0] eo, input logic ec,
                        input logic ev, input logic es);
      exp_t e;
      @(negedge clk);
      a     = ta;
      b     = tb_;
      rst_n = r;
      e.tag = tag; e.ia = ta; e.ib = tb_;
      e.eo = eo; e.ec = ec; e.ev = ev; e.es = es;
      q.push_back(e);
   endtask

   // Monitor: every result is visible #1 after the edge that sampled its operands.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (out !== e.eo || carry !== e.ec || ovf !== e.ev || ovf_sticky !== e.es) begin
               n_fail++;
               $display("FAIL %s a=%0d b=%0d: got out=%0d carry=%b ovf=%b sticky=%b, want out=%0d carry=%b ovf=%b sticky=%b",
                        e.tag, e.ia, e.ib, out, carry, ovf, ovf_sticky, e.eo, e.ec, e.ev, e.es);
            end
         end
      end
   end

   initial begin
      logic [3:0] sa, sb, mo;
      logic       mc, mv, ms;
      int         usum, ssum;

      rst_n = 1'b0;
      a     = '0;
      b     = '0;

      drive("reset_init", 4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      drive("basic_add",  4'd2, 4'd1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0);
      drive("rst_prio",   4'd5, 4'd6, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      // 5+6=11 is also +5 + +6 in signed 4-bit, which overflows.
      drive("rst_release",4'd5, 4'd6, 1'b1, 4'd11, 1'b0, 1'b1, 1'b1);
      drive("wrap",       4'd15,4'd1, 1'b1, WRAP_OUT, 1'b1, 1'b0, 1'b1);
      drive("rst_clr",    4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);
      drive("signed_ovf", 4'd7, 4'd1, 1'b1, 4'd8,  1'b0, 1'b1, 1'b1);
      drive("sticky_hold",4'd1, 4'd1, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1);
      drive("lat_first",  4'd3, 4'd4, 1'b1, 4'd7,  1'b0, 1'b0, 1'b1);

      // Change a mid-cycle; the registered output must not move until the next edge.
      @(posedge clk);
      #2;
      a = 4'd4;
      #1;
      n_cmp++;
      if (out !== 4'd7) begin
         n_fail++;
         $display("FAIL hold_mid_cycle: got out=%0d, want out=7", out);
      end

      drive("lat_second", 4'd4, 4'd4, 1'b1, 4'd8,  1'b0, 1'b1, 1'b1);
      drive("neg_ovf",    4'd8, 4'd8, 1'b1, WRAP_OUT, 1'b1, 1'b1, 1'b1);
      drive("rst_sweep",  4'd0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0);

      ms = 1'b0;
      for (int i = 0; i < 256; i++) begin
         sa   = i[7:4];
         sb   = i[3:0];
         usum = int'(sa) + int'(sb);
         ssum = int'($signed(sa)) + int'($signed(sb));
         mc   = (usum > 15);
         mv   = (ssum > 7) || (ssum < -8);
`ifdef SAMPLE_SAT_EN
         mo   = mc ? 4'd15 : 4'(usum);
`else
         mo   = 4'(usum % 16);
`endif
         ms   = ms | mv;
         drive("sweep", sa, sb, 1'b1, mo, mc, mv, ms);
      end

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d results still pending, want 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sample.md
Name: sample

Overview:
- Registered unsigned adder. Samples operands a and b on every rising clock edge and presents the WIDTH-bit sum one cycle later.
- Also reports unsigned carry-out, two's-complement overflow, and a sticky overflow flag.
- Small datapath leaf block. Used standalone for timing characterisation and as an arithmetic stage in larger pipelines.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A, unsigned (signed view used only for ovf).
- b  input  WIDTH  operand B, unsigned.
- out  output  WIDTH  registered sum (a+b) mod 2^WIDTH, or saturated when SAMPLE_SAT_EN is defined.
- carry  output  1  registered unsigned carry-out of a+b.
- ovf  output  1  registered two's-complement overflow of a+b.
- ovf_sticky  output  1  set when ovf is registered as 1; cleared only by reset.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0, out=0, carry=0, ovf=0 and ovf_sticky=0. Reset takes priority over the sum update.
- No handshake. Inputs are sampled on every rising edge with rst_n=1.
- Latency: exactly 1 cycle. Outputs update on the edge that samples a and b, and hold until the next edge.
- Sum: compute a WIDTH+1-bit sum s = {0,a} + {0,b}.
  - out = s[WIDTH-1:0]; carry = s[WIDTH].
- ovf: 1 when a[MSB]==b[MSB] and s[MSB]!=a[MSB].
- ovf_sticky: on each non-reset edge, ovf_sticky <= ovf_sticky | next_ovf.
- Wrap-around without the optional feature: a=15, b=1 (WIDTH=4) gives out=0 and carry=1.
- Reset mid-stream: the result of the reset cycle's inputs is discarded.
  - Outputs stay 0 until the first edge with rst_n=1, which registers that edge's inputs.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- X on inputs propagates to outputs. No X-masking is required.

Optional Feature:
- Macro: SAMPLE_SAT_EN.
- Defined: unsigned saturation. When carry=1, out = all ones (2^WIDTH-1); otherwise out = sum. carry, ovf and ovf_sticky are computed exactly as without the macro.
- Undefined: out wraps modulo 2^WIDTH as described in Behaviour.

Decomposition:
- Shared package sample_pkg holds:
  - localparam SAMPLE_WIDTH_DEF = 4.
  - Typedef sample_data_t = logic [SAMPLE_WIDTH_DEF-1:0].
  - Typedef sample_flags_t = struct {carry, ovf}.
- Sub-module sample_add: purely combinational.
  - Inputs: a, b.
  - Outputs: sum[WIDTH-1:0], carry, ovf; also applies saturation under SAMPLE_SAT_EN.
- Top-level sample holds the output registers, the sticky flag and the reset logic.

Test Plan:
- Basic add: rst_n=1, a=2, b=1, clk period 10 ns from t=0 -> out=3 at t=10 ns, carry=0, ovf=0.
- Reset priority: a=5, b=6, rst_n=0 for one edge -> out=0, all flags 0. Release rst_n -> next edge out=11.
- Unsigned wrap: a=15, b=1 -> out=0, carry=1, ovf=0. With SAMPLE_SAT_EN: out=15, carry=1.
- Signed overflow: a=7, b=1 -> out=8, ovf=1, carry=0, ovf_sticky=1.
  - Then a=1, b=1 -> out=2, ovf=0, ovf_sticky stays 1 until reset.
- Latency/hold: change a,b between edges (a=3→4 mid-cycle, b=4) -> out shows 7 only after the next edge, then 8 on the following edge. No change mid-cycle.
- Exhaustive sweep: all 256 (a,b) pairs, one per cycle -> each out, carry, ovf matches the reference model one cycle later.
